// File: rtl/dram_burst_model.sv
// Cycle-accurate DRAM model: single-beat writes, queued incrementing read bursts with latency.
// Optional DRAM_STATS_EN adds saturating beat/write counters and the print_stats dump task.
module dram_burst_model #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned MEM_DEPTH   = 262144,
    parameter int unsigned RD_LATENCY  = 4,
    parameter int unsigned BURST_WIDTH = 3,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srstn,
    input  logic                   en_wr,
    input  logic [ADDR_WIDTH-1:0]  addr_wr,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   en_rd,
    input  logic [ADDR_WIDTH-1:0]  addr_rd,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   rd_ready,
    output logic                   valid,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   last,
    output logic                   busy
`ifdef DRAM_STATS_EN
    ,
    output logic [31:0]            stat_rd_beats,
    output logic [31:0]            stat_wr_cnt
`endif
);

    localparam int unsigned AW1   = ADDR_WIDTH + 1;
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned QPW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = QPW + 1;
    localparam int unsigned ENT_W = ADDR_WIDTH + BURST_WIDTH;
    localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    state_t                 state_q, state_d;
    logic [LAT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic [ENT_W-1:0]       q_ent_q [QUEUE_DEPTH];
    logic [ENT_W-1:0]       q_ent_d [QUEUE_DEPTH];
    logic [QPW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d, last_q, last_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   push, pop, beat, q_nempty;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [BURST_WIDTH-1:0] head_len;

    // Address arithmetic is done one bit wider, then reduced modulo the array depth.
    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [AW1-1:0] a);
        return ADDR_WIDTH'(a % AW1'(MEM_DEPTH));
    endfunction

    assign rd_ready  = (count_q != CNT_W'(QUEUE_DEPTH));
    assign push      = en_rd & rd_ready;
    assign q_nempty  = (count_q != '0);
    assign head_addr = q_ent_q[rptr_q][ENT_W-1:BURST_WIDTH];
    assign head_len  = q_ent_q[rptr_q][BURST_WIDTH-1:0];

    assign valid    = valid_q;
    assign last     = last_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;

    // Engine: the WAIT edge where the count has expired already delivers the first beat.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        data_out_d = data_out_q;
        pop        = 1'b0;
        beat       = 1'b0;
        case (state_q)
            IDLE: begin
                if (q_nempty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                    cnt_d   = LAT_INIT;
                    addr_d  = head_addr;
                    rem_d   = head_len;
                end
            end
            WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - LAT_W'(1);
                else             beat  = 1'b1;
            end
            BURST:   beat    = 1'b1;
            default: state_d = IDLE;
        endcase
        if (beat) begin
            valid_d    = 1'b1;
            data_out_d = mem[IDX_W'(addr_q)];
            last_d     = (rem_q == '0);
            addr_d     = wrap_addr({1'b0, addr_q} + AW1'(1));
            rem_d      = rem_q - BURST_WIDTH'(1);
            if (rem_q == '0) begin
                if (q_nempty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                    cnt_d   = LAT_INIT;
                    addr_d  = head_addr;
                    rem_d   = head_len;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                state_d = BURST;
            end
        end
    end

    // Request FIFO; pop only sees entries registered on an earlier edge.
    always_comb begin
        q_ent_d = q_ent_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            q_ent_d[wptr_q] = {addr_rd, burst_len};
            wptr_d          = wptr_q + QPW'(1);
        end
        if (pop) rptr_d = rptr_q + QPW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        busy_d = push | q_nempty | (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        q_ent_q <= q_ent_d;
    end

    // Storage survives reset; beat reads above see the pre-write contents.
    always_ff @(posedge clk) begin
        if (en_wr) mem[IDX_W'(wrap_addr({1'b0, addr_wr}))] <= data_in;
    end

`ifdef DRAM_STATS_EN
    logic [31:0] rd_beats_q, rd_beats_d, wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_beats_d = rd_beats_q;
        wr_cnt_d   = wr_cnt_q;
        if (beat && (rd_beats_q != 32'hFFFF_FFFF)) rd_beats_d = rd_beats_q + 32'd1;
        if (en_wr && (wr_cnt_q != 32'hFFFF_FFFF))  wr_cnt_d   = wr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            rd_beats_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            rd_beats_q <= rd_beats_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign stat_rd_beats = rd_beats_q;
    assign stat_wr_cnt   = wr_cnt_q;

    task automatic print_stats();
        $display("dram_burst_model stats: rd_beats=%0d wr_cnt=%0d", rd_beats_q, wr_cnt_q);
    endtask
`endif

endmodule
